// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared MIPS fetch definitions (reset PC, redirect kinds, fetch FSM states).
package pc_fetch_ctrl_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  typedef enum logic [1:0] {
    REDIR_BRANCH = 2'b00,
    REDIR_JUMP   = 2'b01,
    REDIR_JR     = 2'b10,
    REDIR_RSVD   = 2'b11
  } redir_kind_e;
  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction-memory request/response bus between fetch (master) and memory (slave).
interface pc_fetch_ctrl_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  modport master(output im_req, im_addr, input im_ready, im_rvalid, im_rdata);
  modport slave(input im_req, im_addr, output im_ready, im_rvalid, im_rdata);
endinterface

// File: rtl/pc_fetch_ctrl_npc_calc.sv
// pc_fetch_ctrl_npc_calc: combinational redirect target for branch, j/jal and jr.
module pc_fetch_ctrl_npc_calc
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [1:0]  i_kind,
  input  logic [31:0] i_decode_pc,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_rs_data,
  output logic [31:0] o_target
);
  logic [31:0] w_pc4;
  assign w_pc4 = i_decode_pc + 32'd4;
  always_comb
    o_target = i_kind == REDIR_BRANCH ? w_pc4 + {{14{i_imm16[15]}}, i_imm16, 2'b00} :
               i_kind == REDIR_JUMP   ? {w_pc4[31:28], i_imm26, 2'b00} :
                                        {i_rs_data[31:2], 2'b00};
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: MIPS fetch sequencer with one outstanding imem request and a one-entry decode buffer.
// Build option NO_DELAY_SLOT_EN: redirects take effect immediately instead of after a delay slot.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_stall,
  input  logic                    i_redirect_valid,
  input  logic [1:0]              i_redirect_kind,
  input  logic [31:0]             i_decode_pc,
  input  logic [15:0]             i_imm16,
  input  logic [25:0]             i_imm26,
  input  logic [31:0]             i_rs_data,
  pc_fetch_ctrl_if.master         im,
  output logic                    o_if_valid,
  output logic [31:0]             o_if_instr,
  output logic [31:0]             o_if_pc
);
  fetch_state_e r_state, w_state_nxt;
  logic [31:0] r_pc, r_req_pc, r_if_instr, r_if_pc;
  logic [31:0] w_target, w_pc_acc, w_pc_nxt;
  logic        r_if_valid, r_discard;
  logic        w_accept, w_consume, w_resp, w_redir, w_load, w_kill;

  pc_fetch_ctrl_npc_calc u_npc_calc (
    .i_kind      (i_redirect_kind),
    .i_decode_pc (i_decode_pc),
    .i_imm16     (i_imm16),
    .i_imm26     (i_imm26),
    .i_rs_data   (i_rs_data),
    .o_target    (w_target)
  );

  assign im.im_req  = !reset && r_state == FETCH && (!r_if_valid || !i_stall);
  assign im.im_addr = r_pc;
  assign w_accept   = im.im_req && im.im_ready;
  assign w_consume  = r_if_valid && !i_stall;
  assign w_resp     = r_state == WAIT && im.im_rvalid && !r_discard;

`ifdef NO_DELAY_SLOT_EN
  assign w_redir  = w_consume && i_redirect_valid && i_redirect_kind != REDIR_RSVD;
  assign w_pc_acc = w_accept ? r_pc + 32'd4 : r_pc;
  assign w_pc_nxt = w_redir ? w_target : w_pc_acc;
  // anything fetched after the redirecting instruction is wrong-path
  assign w_load   = w_resp && !w_redir;
  assign w_kill   = w_redir && (r_state == WAIT || w_accept);
`else
  logic [31:0] r_pend_pc;
  logic        r_pend_valid, w_slot;
  assign w_redir  = w_consume && i_redirect_valid && i_redirect_kind != REDIR_RSVD && !r_pend_valid;
  assign w_pc_acc = w_accept ? (r_pend_valid ? r_pend_pc : r_pc + 32'd4) : r_pc;
  // delay slot not yet issued: park the target until the slot request is accepted
  assign w_slot   = w_pc_acc == i_decode_pc + 32'd4;
  assign w_pc_nxt = w_redir && !w_slot ? w_target : w_pc_acc;
  assign w_load   = w_resp;
  assign w_kill   = 1'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      r_pend_valid <= w_redir && w_slot ? 1'b1 : (w_accept ? 1'b0 : r_pend_valid);
      r_pend_pc    <= w_redir && w_slot ? w_target : r_pend_pc;
    end
  end
`endif

  always_comb
    w_state_nxt = r_state == FETCH ? (w_accept ? WAIT : FETCH) : (im.im_rvalid ? FETCH : WAIT);

  always_ff @(posedge clk)
    r_state <= reset ? FETCH : w_state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_discard  <= 1'b1;
    end else begin
      r_pc       <= w_pc_nxt;
      r_req_pc   <= w_accept ? r_pc : r_req_pc;
      r_if_valid <= w_load || (r_if_valid && !w_consume);
      r_if_instr <= w_load ? im.im_rdata : r_if_instr;
      r_if_pc    <= w_load ? r_req_pc : r_if_pc;
      r_discard  <= w_kill || (r_discard && !w_accept);
    end
  end

  assign o_if_valid = r_if_valid;
  assign o_if_instr = r_if_instr;
  assign o_if_pc    = r_if_pc;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: randomized decode/imem stimulus with an architectural PC-sequence scoreboard.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b1, redirect_valid = 1'b0;
  logic [1:0]  redirect_kind = '0;
  logic [31:0] decode_pc = '0, rs_data = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  int vectors = 0, miscompares = 0, delivered = 0;
  logic [31:0] exp_q[$], fq[$];
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  kind;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
  } dir_t;
  dir_t script[$];
  bit random_en = 0, in_slot = 0, m_busy = 0;
  int m_cnt = 0;
  logic [31:0] m_addr = '0;

  pc_fetch_ctrl_if im();

  pc_fetch_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_kind  (redirect_kind),
    .i_decode_pc      (decode_pc),
    .i_imm16          (imm16),
    .i_imm26          (imm26),
    .i_rs_data        (rs_data),
    .im               (im),
    .o_if_valid       (if_valid),
    .o_if_instr       (if_instr),
    .o_if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] target(input logic [31:0] pc, input logic [1:0] k,
                                         input logic [15:0] i16, input logic [25:0] i26,
                                         input logic [31:0] rs);
    logic [31:0] off;
    off = {{16{i16[15]}}, i16};
    if (k == 2'd0) return pc + 32'd4 + off * 32'd4;
    if (k == 2'd1) return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, i26} * 32'd4);
    return rs & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back(a);
    fq.push_back(a);
  endtask

  // decode side: decide whether the instruction being consumed redirects, and predict what follows it
  task automatic decide(input logic [31:0] pc);
    logic rv;
    logic [31:0] t;
    decode_pc = pc;
    imm16 = 16'($urandom);
    imm26 = 26'($urandom);
    rs_data = $urandom;
    redirect_kind = 2'($urandom_range(3));
    rv = 1'b0;
    if (script.size() > 0 && script[0].pc == pc) begin
      rv = 1'b1;
      redirect_kind = script[0].kind;
      imm16 = script[0].i16;
      imm26 = script[0].i26;
      rs_data = script[0].rs;
      void'(script.pop_front());
    end else if (random_en && !in_slot) rv = $urandom_range(3) == 0;
    redirect_valid = rv;
    t = target(pc, redirect_kind, imm16, imm26, rs_data);
`ifdef NO_DELAY_SLOT_EN
    push(rv && redirect_kind != 2'd3 ? t : pc + 32'd4);
`else
    if (in_slot) in_slot = 0;
    else if (rv && redirect_kind != 2'd3) begin
      push(pc + 32'd4);
      push(t);
      in_slot = 1;
    end else push(pc + 32'd4);
`endif
  endtask

  task automatic step();
    @(negedge clk);
    im.im_rvalid = 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        im.im_rvalid = 1'b1;
        im.im_rdata = word(m_addr);
        m_busy = 0;
      end else m_cnt--;
    end
    im.im_ready = !m_busy && $urandom_range(3) != 0;
    redirect_valid = 1'b0;
    stall = reset ? 1'b1 : $urandom_range(4) == 0;
    if (!reset && if_valid && !stall) decide(if_pc);
    #1;
    if (!reset && im.im_req && im.im_ready) begin
      m_busy = 1;
      m_cnt = $urandom_range(2);
      m_addr = im.im_addr;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b1;
    redirect_valid = 1'b0;
    exp_q.delete();
    fq.delete();
    push(RESET_PC_DEF);
    in_slot = 0;
    step();
    step();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_im_req", 32'(im.im_req), 32'd0);
    chk("rst_im_addr", im.im_addr, RESET_PC_DEF);
    reset = 1'b0;
    im.im_ready = 1'b0;
  endtask

  // reset while a request is outstanding; the memory answers it only after reset is released
  task automatic mid_reset();
    int n;
    n = 0;
    while (!m_busy && n < 50) begin
      step();
      n++;
    end
    chk("mid_wait_busy", 32'(m_busy), 32'd1);
    m_cnt = 4;
    step();
    do_reset();
  endtask

  initial begin : monitor
    logic hold;
    logic [31:0] hpc, e;
    hold = 1'b0;
    hpc = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (hold) begin
          vectors++;
          if (!(if_valid && if_pc == hpc)) begin
            miscompares++;
            $display("FAIL stall_hold: if_valid=%b if_pc=%h, expected 1 %h", if_valid, if_pc, hpc);
          end
        end
        if (if_valid && !stall) begin
          vectors++;
          delivered++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL deliver: if_pc=%h delivered, expected nothing", if_pc);
          end else begin
            e = exp_q.pop_front();
            if (if_pc !== e || if_instr !== word(e)) begin
              miscompares++;
              $display("FAIL deliver: if_pc=%h if_instr=%h, expected %h %h", if_pc, if_instr, e, word(e));
            end
          end
        end
`ifndef NO_DELAY_SLOT_EN
        if (im.im_req && im.im_ready) begin
          vectors++;
          if (fq.size() == 0) begin
            miscompares++;
            $display("FAIL fetch: im_addr=%h requested, expected no request", im.im_addr);
          end else begin
            e = fq.pop_front();
            if (im.im_addr !== e) begin
              miscompares++;
              $display("FAIL fetch: im_addr=%h, expected %h", im.im_addr, e);
            end
          end
        end
`endif
      end
      hold = !reset && if_valid && stall;
      hpc = if_pc;
    end
  end

  initial begin
    im.im_ready = 1'b0;
    im.im_rvalid = 1'b0;
    im.im_rdata = '0;
    script.push_back('{32'h0000_3000, 2'd1, 16'h0000, 26'h0000C10, 32'h0});
    do_reset();
    repeat (40) step();
    chk("j_script_used", 32'(script.size()), 32'd0);
    script.delete();
    script.push_back('{32'h0000_3004, 2'd0, 16'hFFFF, 26'h0, 32'h0});
    do_reset();
    repeat (40) step();
    chk("beq_script_used", 32'(script.size()), 32'd0);
    script.delete();
    script.push_back('{32'h0000_3010, 2'd2, 16'h0000, 26'h0, 32'h0000_3103});
    do_reset();
    repeat (60) step();
    chk("jr_script_used", 32'(script.size()), 32'd0);
    script.delete();
    random_en = 1;
    repeat (3000) step();
    repeat (3) begin
      mid_reset();
      repeat (200) step();
    end
    chk("progress", 32'(delivered > 500), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
